// File: rtl/arb_pkg.sv
// Shared types and default widths for the I/D cache-to-memory arbiter.
package arb_pkg;

    localparam int ARB_ADDR_WIDTH = 32;
    localparam int ARB_LINE_WIDTH = 256;

    // Arbiter sequencing: wait, serve one cache, then one quiet cycle.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        RELEASE = 2'd3
    } arb_state_t;

    // Which cache currently owns (or last owned) the memory port.
    typedef enum logic {
        OWNER_I = 1'b0,
        OWNER_D = 1'b1
    } arb_owner_t;

endpackage

// File: rtl/cache_arbiter.sv
// Shares one line-wide memory port between an I-cache and a D-cache.
// One request is latched at a time; the response is routed only to the
// owner, and ties alternate round-robin starting with the D-cache.
module cache_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_WIDTH = ARB_ADDR_WIDTH,
    parameter int LINE_WIDTH = ARB_LINE_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    // I-cache port
    input  logic                  i_pmem_read,
    input  logic [ADDR_WIDTH-1:0] i_pmem_address,
    output logic [LINE_WIDTH-1:0] i_pmem_rdata,
    output logic                  i_pmem_resp,
    // D-cache port
    input  logic                  d_pmem_read,
    input  logic                  d_pmem_write,
    input  logic [ADDR_WIDTH-1:0] d_pmem_address,
    input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
    output logic [LINE_WIDTH-1:0] d_pmem_rdata,
    output logic                  d_pmem_resp,
    // Shared memory port
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [LINE_WIDTH-1:0] mem_wdata,
    input  logic [LINE_WIDTH-1:0] mem_rdata,
    input  logic                  mem_resp
);

    // Two-way round-robin: D wins when alone, or on a tie after an I grant.
    function automatic arb_owner_t pick_owner(input logic i_pend, input logic d_pend,
                                              input arb_owner_t last);
        return (d_pend && (!i_pend || last == OWNER_I)) ? OWNER_D : OWNER_I;
    endfunction

    arb_state_t             state_reg,      state_next;
    arb_owner_t             last_grant_reg, last_grant_next;
    logic                   op_read_reg,    op_read_next;
    logic                   op_write_reg,   op_write_next;
    logic [ADDR_WIDTH-1:0]  addr_reg,       addr_next;
    logic [LINE_WIDTH-1:0]  wdata_reg,      wdata_next;

    logic       i_pending;
    logic       d_pending;
    arb_owner_t grant_owner;
    logic       serving;

    assign i_pending   = i_pmem_read;
    assign d_pending   = d_pmem_read | d_pmem_write;
    assign grant_owner = pick_owner(i_pending, d_pending, last_grant_reg);

    // Next-state and grant/latch selection; everything holds unless granted.
    always_comb begin
        state_next      = state_reg;
        last_grant_next = last_grant_reg;
        op_read_next    = op_read_reg;
        op_write_next   = op_write_reg;
        addr_next       = addr_reg;
        wdata_next      = wdata_reg;
        case (state_reg)
            IDLE: begin
                if (i_pending || d_pending) begin
                    last_grant_next = grant_owner;
                    if (grant_owner == OWNER_D) begin
                        state_next    = SERVE_D;
                        addr_next     = d_pmem_address;
                        wdata_next    = d_pmem_wdata;
                        // Read+write together is illegal; the write-back wins.
                        op_write_next = d_pmem_write;
                        op_read_next  = d_pmem_read & ~d_pmem_write;
                    end else begin
                        state_next    = SERVE_I;
                        addr_next     = i_pmem_address;
                        op_write_next = 1'b0;
                        op_read_next  = 1'b1;
                    end
                end
            end
            SERVE_I, SERVE_D: begin
                if (mem_resp) begin
                    state_next = RELEASE;
                end
            end
            RELEASE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and latch registers; reset abandons any in-flight transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            last_grant_reg <= OWNER_I;
            op_read_reg    <= 1'b0;
            op_write_reg   <= 1'b0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
        end else begin
            state_reg      <= state_next;
            last_grant_reg <= last_grant_next;
            op_read_reg    <= op_read_next;
            op_write_reg   <= op_write_next;
            addr_reg       <= addr_next;
            wdata_reg      <= wdata_next;
        end
    end

    assign serving = (state_reg == SERVE_I) || (state_reg == SERVE_D);

    // Output decode: commands only while serving, response only to the owner.
    always_comb begin
        mem_read     = serving & op_read_reg;
        mem_write    = serving & op_write_reg;
        mem_address  = addr_reg;
        mem_wdata    = wdata_reg;
        i_pmem_resp  = (state_reg == SERVE_I) & mem_resp;
        d_pmem_resp  = (state_reg == SERVE_D) & mem_resp;
        i_pmem_rdata = mem_rdata;
        d_pmem_rdata = mem_rdata;
    end

endmodule

// File: tb/tb_cache_arbiter.sv
// Randomized bench for cache_arbiter with a transaction-level reference model.
module tb_cache_arbiter;

    localparam int AW = 32;
    localparam int LW = 256;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_pmem_read;
    logic [AW-1:0] i_pmem_address;
    logic [LW-1:0] i_pmem_rdata;
    logic          i_pmem_resp;
    logic          d_pmem_read;
    logic          d_pmem_write;
    logic [AW-1:0] d_pmem_address;
    logic [LW-1:0] d_pmem_wdata;
    logic [LW-1:0] d_pmem_rdata;
    logic          d_pmem_resp;
    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] mem_address;
    logic [LW-1:0] mem_wdata;
    logic [LW-1:0] mem_rdata;
    logic          mem_resp;

    always #5 clk = ~clk;

    cache_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_pmem_read    (i_pmem_read),
        .i_pmem_address (i_pmem_address),
        .i_pmem_rdata   (i_pmem_rdata),
        .i_pmem_resp    (i_pmem_resp),
        .d_pmem_read    (d_pmem_read),
        .d_pmem_write   (d_pmem_write),
        .d_pmem_address (d_pmem_address),
        .d_pmem_wdata   (d_pmem_wdata),
        .d_pmem_rdata   (d_pmem_rdata),
        .d_pmem_resp    (d_pmem_resp),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_address    (mem_address),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .mem_resp       (mem_resp)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- stimulus knobs ----------------
    int            i_prob, d_prob;          // percent chance per cycle of a new request
    bit            addr_rand;               // randomize addresses/data (else fixed)
    logic [AW-1:0] i_fix_addr, d_fix_addr;
    int            d_fix_op;                // 0 read, 1 write, 2 both
    bit            i_new, d_new;            // one-shot directed requests
    logic [AW-1:0] i_new_addr, d_new_addr;
    logic [LW-1:0] d_new_wdata;
    int            d_new_op;
    bit            chg_d;                   // perturb D address/data once
    bit            i_drop, d_drop;
    int            fixed_lat;               // -1 = random latency
    bit            spur;                    // allow spurious mem_resp when no command
    bit            rdata_fix;
    bit            mem_pend;
    int            mem_cnt;
    int            i_resp_cnt, d_resp_cnt;
    int            resp_log[$];             // 0 = I served, 1 = D served
    logic [LW-1:0] last_i_rdata;

    // ---------------- reference model ----------------
    bit            m_busy, m_own_d, m_rd, m_wr, m_last_d;
    int            m_gap;                   // IDLE-sampling edges still blocked after a response
    logic [AW-1:0] m_addr;
    logic [LW-1:0] m_wdata;

    task automatic model_reset();
        m_busy = 0; m_own_d = 0; m_rd = 0; m_wr = 0; m_last_d = 0;
        m_gap = 0; m_addr = '0; m_wdata = '0;
    endtask

    function automatic logic [AW-1:0] rand_addr();
        logic [AW-1:0] a;
        a = $urandom;
        return a & ~32'h1F;
    endfunction

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] l;
        for (int k = 0; k < LW / 32; k++) l[k*32 +: 32] = $urandom;
        return l;
    endfunction

    task automatic set_d_op(input int op);
        d_pmem_read  = (op == 0) || (op == 2);
        d_pmem_write = (op == 1) || (op == 2);
    endtask

    // One clock: drive at negedge, check after settling, advance model to next edge.
    task automatic cycle();
        bit ip, dp, gd;
        int r;
        @(negedge clk);
        // I-cache agent
        if (i_drop) begin
            i_pmem_read = 1'b0; i_drop = 0;
        end else if (!i_pmem_read && (i_new || ($urandom_range(99) < i_prob))) begin
            i_pmem_read    = 1'b1;
            i_pmem_address = i_new ? i_new_addr : (addr_rand ? rand_addr() : i_fix_addr);
            i_new = 0;
        end
        // D-cache agent
        if (d_drop) begin
            d_pmem_read = 1'b0; d_pmem_write = 1'b0; d_drop = 0;
        end else if (!(d_pmem_read || d_pmem_write) && (d_new || ($urandom_range(99) < d_prob))) begin
            if (d_new) begin
                set_d_op(d_new_op);
                d_pmem_address = d_new_addr;
                d_pmem_wdata   = d_new_wdata;
                d_new = 0;
            end else begin
                r = $urandom_range(9);
                set_d_op(addr_rand ? ((r == 0) ? 2 : (r < 5) ? 0 : 1) : d_fix_op);
                d_pmem_address = addr_rand ? rand_addr() : d_fix_addr;
                d_pmem_wdata   = rand_line();
            end
        end
        if (addr_rand && ($urandom_range(3) == 0)) i_pmem_address = rand_addr();
        if (addr_rand && ($urandom_range(3) == 0)) begin
            d_pmem_address = rand_addr();
            d_pmem_wdata   = rand_line();
        end
        if (chg_d) begin
            d_pmem_address = 32'h0000_0400;
            d_pmem_wdata   = '0;
            chg_d = 0;
        end
        // memory agent
        mem_resp  = 1'b0;
        mem_rdata = rdata_fix ? {32{8'hA5}} : rand_line();
        if ((mem_read || mem_write) && !mem_pend) begin
            mem_pend = 1;
            mem_cnt  = (fixed_lat >= 0) ? fixed_lat : $urandom_range(0, 6);
        end
        if (mem_pend) begin
            if (mem_cnt == 0) begin
                mem_resp = 1'b1; mem_pend = 0;
            end else begin
                mem_cnt--;
            end
        end else if (spur && ($urandom_range(7) == 0)) begin
            mem_resp = 1'b1;
        end
        #1;
        // compare DUT against model
        chk("mem_read", mem_read, m_busy & m_rd);
        chk("mem_write", mem_write, m_busy & m_wr);
        if (m_busy) begin
            chk("mem_address", mem_address, m_addr);
            chk("mem_wdata", mem_wdata, m_wdata);
        end
        chk("i_resp", i_pmem_resp, m_busy & !m_own_d & mem_resp);
        chk("d_resp", d_pmem_resp, m_busy & m_own_d & mem_resp);
        chk("i_rdata", i_pmem_rdata, mem_rdata);
        chk("d_rdata", d_pmem_rdata, mem_rdata);
        if (i_pmem_resp) begin
            i_drop = 1; i_resp_cnt++; resp_log.push_back(0); last_i_rdata = i_pmem_rdata;
        end
        if (d_pmem_resp) begin
            d_drop = 1; d_resp_cnt++; resp_log.push_back(1);
        end
        // model advance for the coming rising edge
        if (m_busy) begin
            if (mem_resp) begin
                m_busy = 0;
                m_gap  = 1;      // the quiet cycle follows; sampling resumes one edge later
            end
        end else if (m_gap > 0) begin
            m_gap--;
        end else begin
            ip = i_pmem_read;
            dp = d_pmem_read || d_pmem_write;
            if (ip || dp) begin
                if (ip && dp) gd = !m_last_d;
                else          gd = dp;
                m_busy   = 1;
                m_own_d  = gd;
                m_last_d = gd;
                if (gd) begin
                    m_addr  = d_pmem_address;
                    m_wdata = d_pmem_wdata;
                    m_wr    = d_pmem_write;
                    m_rd    = d_pmem_read && !d_pmem_write;
                end else begin
                    m_addr = i_pmem_address;
                    m_rd   = 1; m_wr = 0;
                end
            end
        end
        @(posedge clk);
    endtask

    task automatic drain(input string tag);
        int k;
        bit done;
        done = 0;
        for (k = 0; k < 300 && !done; k++) begin
            cycle();
            done = !m_busy && (m_gap == 0) && !i_pmem_read && !d_pmem_read && !d_pmem_write;
        end
        chk(tag, done, 1'b1);
    endtask

    task automatic wait_busy(input string tag);
        int k;
        for (k = 0; k < 100 && !m_busy; k++) cycle();
        chk(tag, m_busy, 1'b1);
    endtask

    initial begin
        int ic0, dc0, k;
        bit done;
        rst = 1'b1;
        i_pmem_read = 0; i_pmem_address = '0;
        d_pmem_read = 0; d_pmem_write = 0; d_pmem_address = '0; d_pmem_wdata = '0;
        mem_rdata = '0; mem_resp = 0;
        i_prob = 0; d_prob = 0; addr_rand = 0; i_fix_addr = '0; d_fix_addr = '0; d_fix_op = 0;
        i_new = 0; d_new = 0; i_new_addr = '0; d_new_addr = '0; d_new_wdata = '0; d_new_op = 0;
        chg_d = 0; i_drop = 0; d_drop = 0; fixed_lat = -1; spur = 0; rdata_fix = 0;
        mem_pend = 0; mem_cnt = 0; i_resp_cnt = 0; d_resp_cnt = 0; last_i_rdata = '0;
        model_reset();

        // reset state
        #12;
        chk("rst_mem_read", mem_read, 1'b0);
        chk("rst_mem_write", mem_write, 1'b0);
        chk("rst_mem_address", mem_address, '0);
        chk("rst_mem_wdata", mem_wdata, '0);
        chk("rst_i_resp", i_pmem_resp, 1'b0);
        chk("rst_d_resp", d_pmem_resp, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) cycle();

        // lone I read, memory latency 5, line of A5
        fixed_lat = 5; rdata_fix = 1;
        ic0 = i_resp_cnt; dc0 = d_resp_cnt;
        i_new = 1; i_new_addr = 32'h0000_1000;
        for (k = 0; k < 40 && i_resp_cnt == ic0; k++) cycle();
        chk("t1_i_resp_cnt", i_resp_cnt, ic0 + 1);
        chk("t1_d_resp_cnt", d_resp_cnt, dc0);
        chk("t1_i_rdata", last_i_rdata, {32{8'hA5}});
        rdata_fix = 0;
        drain("t1_drain");
        $display("txn lone I read 0x1000: i_resp=%0d d_resp=%0d", i_resp_cnt - ic0, d_resp_cnt - dc0);

        // repeated tie: D first, then alternate
        fixed_lat = -1;
        i_fix_addr = 32'h0000_0100; d_fix_addr = 32'h0000_0200; d_fix_op = 0;
        i_prob = 100; d_prob = 100;
        resp_log.delete();
        for (k = 0; k < 300 && resp_log.size() < 4; k++) cycle();
        i_prob = 0; d_prob = 0;
        drain("t2_drain");
        chk("t2_log_size", (resp_log.size() >= 4), 1'b1);
        if (resp_log.size() >= 4) begin
            chk("t2_order0", resp_log[0], 1);
            chk("t2_order1", resp_log[1], 0);
            chk("t2_order2", resp_log[2], 1);
            chk("t2_order3", resp_log[3], 0);
            $display("txn tie order: %0d %0d %0d %0d", resp_log[0], resp_log[1], resp_log[2], resp_log[3]);
        end

        // D write-back with address/data changed mid-service
        fixed_lat = 6;
        dc0 = d_resp_cnt;
        d_new = 1; d_new_op = 1; d_new_addr = 32'h0000_0300; d_new_wdata = {8{32'hDEAD_BEEF}};
        wait_busy("t3_grant");
        chg_d = 1;
        for (k = 0; k < 40 && d_resp_cnt == dc0; k++) begin
            cycle();
            #1;
            if (mem_write) begin
                chk("t3_addr_hold", mem_address, 32'h0000_0300);
                chk("t3_wdata_hold", mem_wdata, {8{32'hDEAD_BEEF}});
            end
        end
        repeat (4) cycle();
        chk("t3_d_resp_once", d_resp_cnt, dc0 + 1);
        drain("t3_drain");
        $display("txn D write-back 0x300: d_resp=%0d", d_resp_cnt - dc0);

        // spurious mem_resp while idle, then illegal read+write
        ic0 = i_resp_cnt; dc0 = d_resp_cnt;
        spur = 1;
        repeat (20) cycle();
        spur = 0;
        chk("t4_no_i_resp", i_resp_cnt, ic0);
        chk("t4_no_d_resp", d_resp_cnt, dc0);
        fixed_lat = 3;
        d_new = 1; d_new_op = 2; d_new_addr = 32'h0000_0500; d_new_wdata = rand_line();
        wait_busy("t4_grant");
        cycle();
        #1;
        chk("t4_rw_write", mem_write, 1'b1);
        chk("t4_rw_read", mem_read, 1'b0);
        drain("t4_drain");
        $display("txn spurious resp + illegal rd/wr: resp delta i=%0d d=%0d", i_resp_cnt - ic0, d_resp_cnt - dc0 - 1);

        // randomized traffic
        fixed_lat = -1; addr_rand = 1; spur = 1; i_prob = 30; d_prob = 30;
        ic0 = i_resp_cnt; dc0 = d_resp_cnt;
        repeat (1500) cycle();
        i_prob = 0; d_prob = 0; spur = 0; addr_rand = 0;
        drain("t5_drain");
        $display("txn random phase: i served=%0d d served=%0d", i_resp_cnt - ic0, d_resp_cnt - dc0);

        // async reset during a D write-back
        fixed_lat = 40;
        d_new = 1; d_new_op = 1; d_new_addr = 32'h0000_0600; d_new_wdata = rand_line();
        wait_busy("t6_grant");
        cycle();
        #3;
        rst = 1'b1;
        #1;
        chk("t6_rst_write", mem_write, 1'b0);
        chk("t6_rst_read", mem_read, 1'b0);
        chk("t6_rst_addr", mem_address, '0);
        chk("t6_rst_wdata", mem_wdata, '0);
        chk("t6_rst_d_resp", d_pmem_resp, 1'b0);
        model_reset();
        i_pmem_read = 0; d_pmem_read = 0; d_pmem_write = 0; mem_resp = 0;
        mem_pend = 0; i_drop = 0; d_drop = 0;
        @(negedge clk);
        rst = 1'b0;
        fixed_lat = 2;
        resp_log.delete();
        i_new = 1; i_new_addr = 32'h0000_0700;
        d_new = 1; d_new_op = 0; d_new_addr = 32'h0000_0800;
        done = 0;
        for (k = 0; k < 100 && !done; k++) begin
            cycle();
            done = (resp_log.size() >= 2);
        end
        chk("t6_done", done, 1'b1);
        if (done) begin
            chk("t6_first_d", resp_log[0], 1);
            chk("t6_second_i", resp_log[1], 0);
            $display("txn post-reset tie order: %0d %0d", resp_log[0], resp_log[1]);
        end
        drain("t6_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cache_arbiter.md
# cache_arbiter

Two-port arbiter that shares one physical-memory line port between an instruction cache and a data cache. Each cache controller issues full-line reads (I and D) or line write-backs (D only) and holds its request until it receives a response. The arbiter latches one request, drives it to memory, returns the single-cycle response to the owner only, and alternates round-robin when both caches contend.

## Interface
- ADDR_WIDTH, 32, line address width (low 5 bits are always zero from the requesters; passed through unchanged)
- LINE_WIDTH, 256, cache line width in bits
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, asynchronous and active-high
- i_pmem_read  in  1  I-cache line read request; held until i_pmem_resp
- i_pmem_address  in  ADDR_WIDTH  I-cache line address
- i_pmem_rdata  out  LINE_WIDTH  read line to I-cache
- i_pmem_resp  out  1  one-cycle completion pulse to I-cache
- d_pmem_read  in  1  D-cache line read request
- d_pmem_write  in  1  D-cache write-back request
- d_pmem_address  in  ADDR_WIDTH  D-cache line address
- d_pmem_wdata  in  LINE_WIDTH  D-cache write-back data
- d_pmem_rdata  out  LINE_WIDTH  read line to D-cache
- d_pmem_resp  out  1  one-cycle completion pulse to D-cache
- mem_read, mem_write  out  1 each  shared memory command; held until mem_resp
- mem_address  out  ADDR_WIDTH  latched address of the granted request
- mem_wdata  out  LINE_WIDTH  latched write data
- mem_rdata  in  LINE_WIDTH  memory read data, valid with mem_resp
- mem_resp  in  1  one-cycle memory completion

## Operation
- States: IDLE, SERVE_I, SERVE_D, RELEASE.
- IDLE: sample the requests. I pending = i_pmem_read. D pending = d_pmem_read | d_pmem_write.
  - Only one pending: grant it.
  - Both pending: grant the requester that is not last_grant. last_grant resets to I, so D wins the first tie.
- On grant, register the address, the wdata (D only) and the op. D with read and write both asserted is illegal; write wins.
- Update last_grant to the granted requester.
- SERVE_I / SERVE_D:
  - Drive mem_read/mem_write and mem_address/mem_wdata from the latched registers only.
  - Requester input changes are ignored until completion.
  - On mem_resp: pulse the owner's *_resp in the same cycle (combinational from mem_resp & state), then go to RELEASE.
- RELEASE: one cycle with all outputs idle. This lets the owner drop its request so the stale request is not re-granted. Then go to IDLE.
- i_pmem_rdata and d_pmem_rdata are both driven from mem_rdata at all times. Only the *_resp pulse qualifies the data.
- Non-owner *_resp is never asserted. mem_resp in IDLE or RELEASE is ignored.

## Timing
- Reset (async, any state, including mid-transaction):
  - state = IDLE, last_grant = I, latches cleared.
  - mem_read = mem_write = 0, i_pmem_resp = d_pmem_resp = 0, mem_address = 0, mem_wdata = 0.
  - An in-flight memory transaction is abandoned.
- Request visible in IDLE at edge N → mem_read/mem_write asserted from cycle N+1.
- Requester response occurs in the same cycle as mem_resp.
- Back-to-back requests: at least 2 idle cycles between mem_resp and the next memory command (RELEASE, then IDLE grant).
- Total overhead: 3 cycles plus memory latency per transaction.
- A request arriving during SERVE_x or RELEASE waits; it is considered at the next IDLE.
- mem_resp arriving in the grant cycle itself is handled normally. The command was already asserted for one cycle.
- mem_address and mem_wdata are stable for the whole SERVE_x interval.

## Structure
- Shared package arb_pkg:
  - arb_state_t enum (IDLE, SERVE_I, SERVE_D, RELEASE).
  - arb_owner_t enum (OWNER_I, OWNER_D).
  - Default ADDR_WIDTH/LINE_WIDTH constants.
- Single module with three parts: state/next-state FSM, grant/latch registers, output decode.
- No sub-module; the two-way round-robin pick is a one-line function inside.

## Test plan
- Reset: assert rst mid-SERVE_D with mem_write=1 → mem_write drops immediately (async); after release, idle outputs and next tie grants D.
- Lone I read of 0x0000_1000, memory responds after 5 cycles with line 0xA5..A5 → mem_read from cycle 1; i_pmem_resp pulses with mem_resp and rdata 0xA5..A5; d_pmem_resp stays 0.
- Simultaneous I read 0x100 and D read 0x200 held → D served first (mem_address=0x200), then RELEASE, IDLE, I served (0x100); repeat tie → order D, I, D, I.
- D write-back 0x300 with wdata 0xDEAD..BEEF, d_pmem_address changed to 0x400 mid-service → mem_address stays 0x300 and mem_wdata unchanged until mem_resp; exactly one d_pmem_resp.
- Spurious mem_resp in IDLE → no *_resp asserted, no state change; D with read and write both high → mem_write=1, mem_read=0.
